// File: rtl/mdu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_seq_ctrl
// Description : Iterative multiply/divide sequencer for the EX stage.
//               Shift-add multiply or restoring divide, one bit per clock,
//               with sign fix-up, HI/LO writeback, pipeline stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                c_cnt_w     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched operation context
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [WIDTH:0]     r_x_mag;     // multiplicand magnitude (W+1 bits so |-2^(W-1)| fits)
  logic [WIDTH:0]     r_y_mag;     // divisor magnitude
  logic [c_cnt_w-1:0] r_cnt;

  // Working registers: multiply uses {r_rem[W-1:0], r_q} as the 2W accumulator,
  // divide uses r_rem as the W+1 bit partial remainder and r_q as the quotient.
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_q;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operand sign handling at issue
  logic               w_x_neg;
  logic               w_y_neg;
  logic [WIDTH:0]     w_x_ext;
  logic [WIDTH:0]     w_y_ext;
  logic [WIDTH:0]     w_x_mag;
  logic [WIDTH:0]     w_y_mag;
  logic               w_dbz;
  logic               w_accept;

  // Iteration datapath
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH+1:0]   w_div_trial;
  logic               w_div_ok;

  // Final sign fix-up
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_x_neg  = op[0] & x[WIDTH-1];
  assign w_y_neg  = op[0] & y[WIDTH-1];
  assign w_x_ext  = {w_x_neg, x};
  assign w_y_ext  = {w_y_neg, y};
  assign w_x_mag  = w_x_neg ? -w_x_ext : w_x_ext;
  assign w_y_mag  = w_y_neg ? -w_y_ext : w_y_ext;
  assign w_dbz    = op[1] & (y == '0);
  assign w_accept = (r_state == S_IDLE) & start & ~flush;

  assign w_mul_sum   = r_rem + (r_q[0] ? r_x_mag : '0);
  assign w_div_shift = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_div_trial = {1'b0, w_div_shift} - {1'b0, r_y_mag};
  assign w_div_ok    = ~w_div_trial[WIDTH+1];

  assign w_prod     = {r_rem[WIDTH-1:0], r_q};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
  assign w_quot_fix = r_neg_res ? -r_q : r_q;
  assign w_rem_fix  = r_neg_rem ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status decode; flush wins over everything once an op is live
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_dbz ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_last_iter) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        busy        = 1'b1;
        w_state_nxt = flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Divide-by-zero completes in one edge, so it never needs to hold the pipe
  assign stall = busy | (start & (r_state == S_IDLE) & ~w_dbz);

  // Operand latch, per-bit iteration and HI/LO writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_x_mag   <= '0;
      r_y_mag   <= '0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div  <= op[1];
            r_neg_res <= w_x_neg ^ w_y_neg;
            r_neg_rem <= w_x_neg;
            r_x_mag   <= w_x_mag;
            r_y_mag   <= w_y_mag;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_q       <= op[1] ? w_x_mag[WIDTH-1:0] : w_y_mag[WIDTH-1:0];
            if (w_dbz) begin
              r_hi <= x;
              r_lo <= '1;
            end
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_cnt <= r_cnt + c_cnt_one;
            if (r_is_div) begin
              r_rem <= w_div_ok ? w_div_trial[WIDTH:0] : w_div_shift;
              r_q   <= {r_q[WIDTH-2:0], w_div_ok};
            end else begin
              r_rem <= {1'b0, w_mul_sum[WIDTH:1]};
              r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
            end
          end
        end
        S_FIX: begin
          if (!flush) begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quot_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_seq_ctrl
// Description : Self-checking bench for mdu_seq_ctrl: directed corner cases
//               plus randomized operations against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_seq_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         flush;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  // Values hi/lo must currently hold
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  mdu_seq_ctrl #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .x     (x),
    .y     (y),
    .flush (flush),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: results straight from 64-bit integer math
  task automatic ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] mh, output logic [W-1:0] ml);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    if (o[1] && b == '0) begin
      mh = a;
      ml = '1;
    end else begin
      case (o)
        2'd0: begin p = {32'd0, a} * {32'd0, b}; mh = p[63:32]; ml = p[31:0]; end
        2'd1: begin p = sa * sb;                 mh = p[63:32]; ml = p[31:0]; end
        2'd2: begin ml = a / b;                  mh = a % b; end
        default: begin q = sa / sb; r = sa % sb; ml = q[31:0]; mh = r[31:0]; end
      endcase
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and watch it cycle by cycle. inj_k: cycle (after start) in which a
  // stray start is pulsed; flush_k: cycle in which flush is held. 0 disables either.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inj_k, input int flush_k);
    logic [W-1:0] mh;
    logic [W-1:0] ml;
    logic [W-1:0] got_hi;
    logic [W-1:0] got_lo;
    bit           dbz;
    bit           hold_ok;
    bit           stall_ok;
    int           lat;
    int           busy_n;
    int           done_at;
    ref_model(o, a, b, mh, ml);
    dbz      = o[1] && (b == '0);
    lat      = dbz ? 1 : W + 2;
    busy_n   = 0;
    done_at  = 0;
    hold_ok  = 1'b1;
    stall_ok = 1'b1;
    got_hi   = '0;
    got_lo   = '0;

    op = o; x = a; y = b; start = 1'b1; flush = 1'b0;
    #1;
    check_eq({tag, "/stall_at_start"}, 64'(stall), 64'(!dbz));
    step();
    for (int k = 1; k <= W + 4; k++) begin
      start = 1'b0;
      flush = 1'b0;
      x = $urandom;
      y = $urandom;
      op = 2'($urandom_range(0, 3));
      #1;
      if (done && done_at == 0) begin
        done_at = k;
        got_hi  = hi;
        got_lo  = lo;
      end
      if (busy) busy_n++;
      if (stall !== busy) stall_ok = 1'b0;
      if (done_at == 0 && k < lat && (hi !== exp_hi || lo !== exp_lo)) hold_ok = 1'b0;
      if (k == flush_k) flush = 1'b1;
      if (k == inj_k) start = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    flush = 1'b0;
    #1;

    check_eq({tag, "/hold_during_op"}, 64'(hold_ok), 64'd1);
    check_eq({tag, "/stall_tracks_busy"}, 64'(stall_ok), 64'd1);
    if (flush_k > 0) begin
      check_eq({tag, "/no_done_after_flush"}, 64'(done_at), 64'd0);
      check_eq({tag, "/busy_cycles_flushed"}, 64'(busy_n), 64'(flush_k));
      check_eq({tag, "/hi_kept"}, 64'(hi), 64'(exp_hi));
      check_eq({tag, "/lo_kept"}, 64'(lo), 64'(exp_lo));
    end else begin
      check_eq({tag, "/done_latency"}, 64'(done_at), 64'(lat));
      check_eq({tag, "/busy_cycles"}, 64'(busy_n), 64'(dbz ? 0 : W + 1));
      check_eq({tag, "/hi"}, 64'(got_hi), 64'(mh));
      check_eq({tag, "/lo"}, 64'(got_lo), 64'(ml));
      exp_hi = mh;
      exp_lo = ml;
    end
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           inj;
    int           fl;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; x = '0; y = '0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) step();
    check_eq("reset/busy",  64'(busy),  64'd0);
    check_eq("reset/stall", 64'(stall), 64'd0);
    check_eq("reset/done",  64'(done),  64'd0);
    check_eq("reset/hi",    64'(hi),    64'd0);
    check_eq("reset/lo",    64'(lo),    64'd0);
    rst_n = 1'b1;
    step();

    run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check_eq("plan/multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check_eq("plan/multu_lo", 64'(lo), 64'h0000_0001);

    run_op("mult_m7x6", 2'd1, 32'hFFFF_FFF9, 32'd6, 0, 0);
    check_eq("plan/mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check_eq("plan/mult_lo", 64'(lo), 64'hFFFF_FFD6);

    run_op("div_m7d2", 2'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check_eq("plan/div_hi", 64'(hi), 64'hFFFF_FFFF);
    check_eq("plan/div_lo", 64'(lo), 64'hFFFF_FFFD);

    run_op("divu_by_zero", 2'd2, 32'd100, 32'd0, 0, 0);
    check_eq("plan/dbz_hi", 64'(hi), 64'd100);
    check_eq("plan/dbz_lo", 64'(lo), 64'hFFFF_FFFF);

    run_op("divu_flushed", 2'd2, 32'd100, 32'd7, 0, 10);
    run_op("divu_after_flush", 2'd2, 32'd100, 32'd7, 0, 0);
    check_eq("plan/divu_hi", 64'(hi), 64'd2);
    check_eq("plan/divu_lo", 64'(lo), 64'd14);

    run_op("multu_stray_start", 2'd0, 32'd3, 32'd5, 5, 0);
    check_eq("plan/multu3x5_hi", 64'(hi), 64'd0);
    check_eq("plan/multu3x5_lo", 64'(lo), 64'd15);

    run_op("div_min_by_m1", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check_eq("plan/divmin_hi", 64'(hi), 64'd0);
    check_eq("plan/divmin_lo", 64'(lo), 64'h8000_0000);
    run_op("mult_min_by_m1", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check_eq("plan/multmin_hi", 64'(hi), 64'd0);
    check_eq("plan/multmin_lo", 64'(lo), 64'h8000_0000);

    run_op("div_flush_in_fix", 2'd3, 32'd12345, 32'd17, 0, W + 1);
    run_op("mult_stray_in_done", 2'd1, 32'd9, 32'hFFFF_FFFE, W + 2, 0);

    // flush together with start in IDLE: the start must be dropped
    op = 2'd0; x = 32'd3; y = 32'd5; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    #1;
    check_eq("idle_flush_start/busy", 64'(busy), 64'd0);
    check_eq("idle_flush_start/done", 64'(done), 64'd0);
    step();
    check_eq("idle_flush_start/busy_next", 64'(busy), 64'd0);
    check_eq("idle_flush_start/hi", 64'(hi), 64'(exp_hi));

    // asynchronous reset in the middle of an operation
    op = 2'd0; x = $urandom; y = $urandom; start = 1'b1;
    step();
    start = 1'b0;
    repeat ($urandom_range(3, 30)) step();
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset/busy",  64'(busy),  64'd0);
    check_eq("async_reset/stall", 64'(stall), 64'd0);
    check_eq("async_reset/done",  64'(done),  64'd0);
    check_eq("async_reset/hi",    64'(hi),    64'd0);
    check_eq("async_reset/lo",    64'(lo),    64'd0);
    step();
    rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    step();

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = rand_operand();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_operand();
      inj = 0;
      fl  = 0;
      if (!(ro[1] && rb == '0)) begin
        if ($urandom_range(0, 4) == 0) fl = $urandom_range(1, W + 1);
        else if ($urandom_range(0, 3) == 0) inj = $urandom_range(2, W + 2);
      end
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, inj, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in the EX stage. Takes the X operand and the selected Y operand (after the Y-operand mux).
- Runs an iterative shift-add multiply or restoring divide, one bit per clock, and writes HI/LO.
- Drives a stall to the pipeline controller while busy. Accepts an abort (flush) from exception/branch logic.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- x  in  WIDTH  operand A (multiplicand/dividend); sampled with start.
- y  in  WIDTH  operand B (multiplier/divisor) from the Y mux; sampled with start.
- flush  in  1  abort the current operation.
- busy  out  1  high in any state other than IDLE and DONE.
- stall  out  1  busy | (start & state==IDLE & ~div_by_zero_fast).
- done  out  1  one-cycle completion pulse.
- hi  out  WIDTH  product high word / remainder.
- lo  out  WIDTH  product low word / quotient.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - busy, done, hi, lo, iteration counter, working registers all 0.
  - stall = 0.
  - Takes effect immediately, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE with start=1 at edge E0:
  - Latch op, x, y.
  - Signed ops (MULT, DIV): latch magnitudes |x|, |y|, plus neg_res = x[W-1]^y[W-1] and neg_rem = x[W-1].
  - Unsigned ops: neg flags = 0.
  - Counter = 0; go to CALC.
- Divide by zero (op[1]=1, y=0):
  - Skip CALC/FIX and go straight to DONE at E0.
  - Results: hi = x (unmodified, signed or not), lo = all ones.
  - done=1 in the cycle after E0.
  - stall is not raised for the start cycle (div_by_zero_fast).
- CALC: one iteration per edge, WIDTH edges total; counter increments and after the WIDTH-th iteration the state goes to FIX.
  - Multiply: 2*WIDTH-bit accumulator {acc_hi, mplier}. If the LSB is 1, acc_hi += mcand using a WIDTH+1-bit add. The whole accumulator then shifts right 1 with the carry entering at the top.
  - Divide (restoring): rem is WIDTH+1 bits.
    - Shift {rem, quot} left 1; trial = rem - divisor.
    - If trial is non-negative: rem = trial, quot[0] = 1. Otherwise quot[0] = 0.
- FIX: one edge.
  - Multiply: if neg_res, negate the 2*WIDTH result; hi/lo = result[2W-1:W] / result[W-1:0].
  - Divide: lo = neg_res ? -quot : quot; hi = neg_rem ? -rem : rem.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - start is not accepted in DONE; it is accepted on the next IDLE cycle.
- Latency: start in cycle t gives done in cycle t+WIDTH+2, i.e. t+34 for WIDTH=32.
  - busy is high during cycles t+1 .. t+WIDTH+1.
- hi/lo are written only at the FIX edge (or the divide-by-zero edge) and hold between operations.
  - hi/lo are never partially updated.
- start while busy: ignored; no re-latch.
- flush in any state except IDLE:
  - At the next edge return to IDLE with no done pulse.
  - hi/lo keep their previous values.
  - flush has priority over start and over the FIX writeback.
- flush and start together in IDLE: start is ignored.
- Signed edge case: MULT of -2^31 by -1 gives hi=0, lo=0x8000_0000.
  - Magnitude latching must use WIDTH+1-bit unsigned values so that |-2^31| does not overflow.
- DIV -2^31 / -1: lo=0x8000_0000, hi=0 (wraps, no trap).

Test Plan:
- MULTU x=0xFFFF_FFFF, y=0xFFFF_FFFF -> done at t+34; hi=0xFFFF_FFFE, lo=0x0000_0001; busy high for exactly 33 cycles.
- MULT x=-7 (0xFFFF_FFF9), y=6 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFD6. DIV x=-7, y=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
- DIVU x=100, y=0 -> done at t+1; hi=100, lo=0xFFFF_FFFF; stall never asserted.
- DIVU x=100, y=7 started, flush at t+10 -> no done pulse; IDLE at t+11; hi/lo equal their pre-op values. A new start at t+12 completes normally (lo=14, hi=2).
- start pulsed at t+5 during a busy MULTU 3×5 -> ignored; result hi=0, lo=15. Then rst_n=0 mid-op at an arbitrary cycle -> all outputs 0 immediately, asynchronously.
- DIV x=0x8000_0000, y=0xFFFF_FFFF -> lo=0x8000_0000, hi=0. MULT of the same operands -> hi=0, lo=0x8000_0000.
